// File: rtl/recirculacion_merge.sv
// recirculacion_merge: per-lane merge of fresh and recirculated words; fresh wins, recirculated words wait in a lane FIFO
module recirculacion_merge #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int AF_THRESHOLD = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_0,
    input  logic [DATA_WIDTH-1:0] data_1,
    input  logic [DATA_WIDTH-1:0] data_2,
    input  logic [DATA_WIDTH-1:0] data_3,
    input  logic                  valid_0,
    input  logic                  valid_1,
    input  logic                  valid_2,
    input  logic                  valid_3,
    input  logic [DATA_WIDTH-1:0] data_0r,
    input  logic [DATA_WIDTH-1:0] data_1r,
    input  logic [DATA_WIDTH-1:0] data_2r,
    input  logic [DATA_WIDTH-1:0] data_3r,
    input  logic                  valid_0r,
    input  logic                  valid_1r,
    input  logic                  valid_2r,
    input  logic                  valid_3r,
    output logic [DATA_WIDTH-1:0] data_out_0,
    output logic [DATA_WIDTH-1:0] data_out_1,
    output logic [DATA_WIDTH-1:0] data_out_2,
    output logic [DATA_WIDTH-1:0] data_out_3,
    output logic                  valid_out_0,
    output logic                  valid_out_1,
    output logic                  valid_out_2,
    output logic                  valid_out_3,
    output logic                  pause_0,
    output logic                  pause_1,
    output logic                  pause_2,
    output logic                  pause_3,
    output logic                  overflow,
    output logic                  idle_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF = CW'(AF_THRESHOLD);
    logic [DATA_WIDTH-1:0] din [4];
    logic [DATA_WIDTH-1:0] rin [4];
    logic [3:0] vin, vr, drop, quiet;
    logic overflow_q, idle_q;
    assign din = '{data_0, data_1, data_2, data_3};
    assign rin = '{data_0r, data_1r, data_2r, data_3r};
    assign vin = {valid_3, valid_2, valid_1, valid_0};
    assign vr = {valid_3r, valid_2r, valid_1r, valid_0r};
    genvar n;
    for (n = 0; n < 4; n++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [DATA_WIDTH-1:0] dout_q, dout_d;
        logic [PW-1:0] wp_q, rp_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic vout_q, pause_q, pop, push;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts a push while draining
        always_comb begin
            pop = !vin[n] && cnt_q != '0;
            push = vr[n] && (cnt_q != FULL || pop);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            dout_d = vin[n] ? din[n] : pop ? mem_q[rp_q] : dout_q;
        end
        assign drop[n] = vr[n] && !push;
        assign quiet[n] = cnt_d == '0 && !vin[n] && !vr[n];
        always_ff @(posedge clk) begin
            if (push) mem_q[wp_q] <= rin[n];
        end
        always_ff @(posedge clk) begin
            if (reset) begin
                wp_q <= '0;
                rp_q <= '0;
                cnt_q <= '0;
                dout_q <= '0;
                vout_q <= 1'b0;
                pause_q <= 1'b0;
            end else begin
                wp_q <= wp_q + PW'(push);
                rp_q <= rp_q + PW'(pop);
                cnt_q <= cnt_d;
                dout_q <= dout_d;
                vout_q <= vin[n] || pop;
                pause_q <= cnt_d >= AF;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            overflow_q <= overflow_q || (|drop);
            idle_q <= &quiet;
        end
    end
    assign data_out_0 = g_lane[0].dout_q;
    assign data_out_1 = g_lane[1].dout_q;
    assign data_out_2 = g_lane[2].dout_q;
    assign data_out_3 = g_lane[3].dout_q;
    assign valid_out_0 = g_lane[0].vout_q;
    assign valid_out_1 = g_lane[1].vout_q;
    assign valid_out_2 = g_lane[2].vout_q;
    assign valid_out_3 = g_lane[3].vout_q;
    assign pause_0 = g_lane[0].pause_q;
    assign pause_1 = g_lane[1].pause_q;
    assign pause_2 = g_lane[2].pause_q;
    assign pause_3 = g_lane[3].pause_q;
    assign overflow = overflow_q;
    assign idle_out = idle_q;
endmodule
